// File: rtl/display_pkg.sv
// display_pkg: shared types and defaults for the display feeder.
package display_pkg;
  localparam int DW = 16;
  localparam int TICK_DIV_DEF = 50000;
  localparam int DWELL_DEF = 400;
  typedef enum logic [1:0] {IDLE, READ, LATCH, HOLD} state_e;
endpackage

// File: rtl/feeder_ram.sv
// feeder_ram: 2**AW x 16 simple dual-port memory, synchronous read, no reset.
module feeder_ram
  import display_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd <= mem[ra];
  end
endmodule

// File: rtl/display_feeder.sv
// display_feeder: scans a host-written word memory and feeds a stable word plus digit strobe
// to the display stage. Define SHOW_ADDR_EN to show cur_addr in the leftmost digit.
module display_feeder
  import display_pkg::*;
#(
  parameter int AW       = 4,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int DWELL    = DWELL_DEF
) (
  input  logic          clk_main,
  input  logic          rst_n,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          run,
  input  logic          step,
  output logic [DW-1:0] data,
  output logic          data_valid,
  output logic [AW-1:0] cur_addr,
  output logic          scan_tick
);
  localparam int CW  = $clog2(TICK_DIV);
  localparam int DWW = $clog2(DWELL + 1);
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DWW-1:0] dwell_q, dwell_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d, rd_word, shown;
  logic          valid_q, valid_d, rdy_q, step_q, refresh_q, refresh_d;
  logic          tick, wr_fire, step_rise, hit;
  feeder_ram #(.AW(AW)) u_ram (
    .clk(clk_main), .we(wr_fire), .wa(wr_addr), .wd(wr_data), .ra(addr_q), .rd(rd_word)
  );
`ifdef SHOW_ADDR_EN
  assign shown = {4'(addr_q), rd_word[11:0]};
`else
  assign shown = rd_word;
`endif
  always_comb begin
    tick      = cnt_q == CW'(TICK_DIV - 1);
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    wr_fire   = wr_valid && rdy_q;
    step_rise = step && !step_q;
    hit       = wr_fire && wr_addr == addr_q;
    state_d   = state_q;
    addr_d    = addr_q;
    dwell_d   = dwell_q;
    data_d    = data_q;
    valid_d   = valid_q;
    refresh_d = refresh_q || hit;
    case (state_q)
      IDLE:  state_d = (run || step_rise) ? READ : IDLE;
      READ:  state_d = LATCH;
      LATCH: begin
        data_d  = shown;
        valid_d = 1'b1;
        dwell_d = '0;
        state_d = HOLD;
      end
      default: begin
        // a refresh rereads the same word, so a write landing this cycle is still seen
        if (refresh_q) begin
          refresh_d = hit;
          state_d   = READ;
        end else if (run && tick && dwell_q == DWW'(DWELL - 1)) begin
          addr_d  = addr_q + 1'b1;
          state_d = READ;
        end else if (!run && step_rise) begin
          addr_d  = addr_q + 1'b1;
          state_d = READ;
        end else begin
          dwell_d = run ? dwell_q + DWW'(tick) : '0;
        end
      end
    endcase
  end
  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dwell_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      rdy_q     <= 1'b0;
      step_q    <= 1'b0;
      refresh_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dwell_q   <= dwell_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      rdy_q     <= 1'b1;
      step_q    <= step;
      refresh_q <= refresh_d;
    end
  end
  assign wr_ready   = rdy_q;
  assign data       = data_q;
  assign data_valid = valid_q;
  assign cur_addr   = addr_q;
  assign scan_tick  = tick;
endmodule
